// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register slave:
// FSM encoding, instruction field order, word-count codes.
package spi_reg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INSTR,
      WDATA,
      RFETCH,
      RDATA,
      DONE
   } state_t;

   // Field positions in transmission order within the instruction.
   localparam int RW_IDX   = 0;
   localparam int W1_IDX   = 1;
   localparam int W0_IDX   = 2;
   localparam int ADDR_IDX = 3;

   localparam logic [1:0] W1W0_STREAM = 2'b11;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises sclk/csb/sdi into clk; emits one-clk edge pulses.
// Ports: sclk/csb/sdi in; sclk_rise/fall, csb_rise/fall, sdi_smp out.
module spi_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstb,
   input  logic sclk,
   input  logic csb,
   input  logic sdi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic csb_fall,
   output logic csb_rise,
   output logic sdi_smp
);

   logic [SYNC_STAGES-1:0] sclk_q;
   logic [SYNC_STAGES-1:0] csb_q;
   logic [SYNC_STAGES-1:0] sdi_q;
   logic                   sclk_d;
   logic                   csb_d;

   // csb resets to its deasserted level so release
   // of reset never looks like a chip-select edge.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sclk_q <= '0;
         csb_q  <= '1;
         sdi_q  <= '0;
         sclk_d <= 1'b0;
         csb_d  <= 1'b1;
      end else begin
         sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
         csb_q  <= {csb_q[SYNC_STAGES-2:0], csb};
         sdi_q  <= {sdi_q[SYNC_STAGES-2:0], sdi};
         sclk_d <= sclk_q[SYNC_STAGES-1];
         csb_d  <= csb_q[SYNC_STAGES-1];
      end
   end

   assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
   assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
   assign csb_rise  = csb_q[SYNC_STAGES-1] & ~csb_d;
   assign csb_fall  = ~csb_q[SYNC_STAGES-1] & csb_d;
   // Same depth as sclk, so it is the bit present at the sclk rise.
   assign sdi_smp   = sdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// Oversampled SPI slave driving a register-file port (R/W, W1:W0, addr).
// Ports: SPI sclk/csb/sdi/sdo/sdo_oe; reg_addr, wr_data/wr_stb, rd_stb/rd_data.
module spi_reg_slave
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W      = 13,
   parameter int DATA_W      = 8,
   parameter int LSB_FIRST   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              sclk,
   input  logic              csb,
   input  logic              sdi,
   input  logic              ascend,
   output logic              sdo,
   output logic              sdo_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_stb,
   output logic              rd_stb,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy
);

   localparam int IW = ADDR_W + 3;
   localparam int CW = $clog2((IW > DATA_W ? IW : DATA_W) + 1);
   localparam logic [CW-1:0] INS_LAST  = CW'(IW - 1);
   localparam logic [CW-1:0] WORD_LAST = CW'(DATA_W - 1);

   logic sclk_rise, sclk_fall, csb_fall, csb_rise, sdi_smp;

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rstb      (rstb),
      .sclk      (sclk),
      .csb       (csb),
      .sdi       (sdi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .csb_fall  (csb_fall),
      .csb_rise  (csb_rise),
      .sdi_smp   (sdi_smp)
   );

   state_t            state, nxt;
   logic [CW-1:0]     cnt;
   logic [IW-2:0]     ins;
   logic [IW-1:0]     ins_nx;
   logic [DATA_W-1:0] rx, rx_nx, tx, tx_sh;
   logic [ADDR_W-1:0] addr, addr_dec, addr_step;
   logic [1:0]        w_fld, left;
   logic              dir, stream, more, fetch_ph;
   logic              ins_last, word_last;

   assign ins_nx    = {ins, sdi_smp};
   assign w_fld     = {ins_nx[IW-1-W1_IDX], ins_nx[IW-1-W0_IDX]};
   assign ins_last  = sclk_rise && cnt == INS_LAST;
   assign word_last = sclk_rise && cnt == WORD_LAST;
   assign more      = stream || left != 2'd0;
   assign addr_step = dir ? addr + 1'b1 : addr - 1'b1;

   assign rx_nx = (LSB_FIRST != 0) ? {sdi_smp, rx[DATA_W-1:1]}
                                   : {rx[DATA_W-2:0], sdi_smp};
   assign tx_sh = (LSB_FIRST != 0) ? {1'b0, tx[DATA_W-1:1]}
                                   : {tx[DATA_W-2:0], 1'b0};

   // Address bits arrive in the configured order; first bit lands highest.
   always_comb begin
      addr_dec = '0;
      for (int i = 0; i < ADDR_W; i++)
         addr_dec[i] = (LSB_FIRST != 0) ? ins_nx[ADDR_W-1-i] : ins_nx[i];
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (state != IDLE && csb_rise) begin
         nxt = IDLE;
      end else begin
         case (state)
            IDLE:   if (csb_fall) nxt = INSTR;
            INSTR:  if (ins_last)
                       nxt = ins_nx[IW-1-RW_IDX] ? RFETCH : WDATA;
            WDATA:  if (word_last) nxt = more ? WDATA : DONE;
            RFETCH: if (fetch_ph) nxt = RDATA;
            RDATA:  if (word_last) nxt = more ? RFETCH : DONE;
            DONE:   nxt = DONE;
            default: nxt = IDLE;
         endcase
      end
   end

   assign rd_stb   = (state == RFETCH) && !fetch_ph;
   assign busy     = (state != IDLE);
   assign reg_addr = addr;
   assign sdo      = sdo_oe & ((LSB_FIRST != 0) ? tx[0] : tx[DATA_W-1]);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt      <= '0;
         ins      <= '0;
         rx       <= '0;
         tx       <= '0;
         addr     <= '0;
         dir      <= 1'b0;
         stream   <= 1'b0;
         left     <= 2'd0;
         fetch_ph <= 1'b0;
         wr_stb   <= 1'b0;
         wr_data  <= '0;
         sdo_oe   <= 1'b0;
      end else begin
         wr_stb <= 1'b0;
         // Step only after the strobe so reg_addr is stable under it.
         if (wr_stb) addr <= addr_step;
         if (state != IDLE && csb_rise) begin
            cnt      <= '0;
            fetch_ph <= 1'b0;
            sdo_oe   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt      <= '0;
                  fetch_ph <= 1'b0;
                  sdo_oe   <= 1'b0;
               end
               INSTR: if (sclk_rise) begin
                  ins <= ins_nx[IW-2:0];
                  cnt <= cnt + 1'b1;
                  if (ins_last) begin
                     cnt    <= '0;
                     addr   <= addr_dec;
                     dir    <= ascend;
                     left   <= w_fld;
                     stream <= (w_fld == W1W0_STREAM);
                  end
               end
               WDATA: if (sclk_rise) begin
                  rx  <= rx_nx;
                  cnt <= cnt + 1'b1;
                  if (word_last) begin
                     cnt     <= '0;
                     wr_stb  <= 1'b1;
                     wr_data <= rx_nx;
                     if (!stream && left != 2'd0) left <= left - 2'd1;
                  end
               end
               RFETCH: begin
                  fetch_ph <= ~fetch_ph;
                  if (fetch_ph) begin
                     tx     <= rd_data;
                     sdo_oe <= 1'b1;
                  end
               end
               RDATA: begin
                  // The fall before the first data rise must not shift.
                  if (sclk_fall && cnt != '0) tx <= tx_sh;
                  if (sclk_rise) begin
                     cnt <= cnt + 1'b1;
                     if (word_last) begin
                        cnt  <= '0;
                        addr <= addr_step;
                        if (!stream && left != 2'd0) left <= left - 2'd1;
                        if (!more) sdo_oe <= 1'b0;
                     end
                  end
               end
               DONE: sdo_oe <= 1'b0;
               default: cnt <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed + randomized bench for spi_reg_slave (8-bit MSB-first and
// 16-bit LSB-first instances sharing one SPI host).
module tb_spi_reg_slave;

   logic clk = 1'b0;
   logic rstb, sclk, sdi, ascend, csb0, csb1;
   logic sdo0, oe0, ws0, rs0, busy0;
   logic sdo1, oe1, ws1, rs1, busy1;
   logic [12:0] addr0, addr1;
   logic [7:0]  wd0, rd0;
   logic [15:0] wd1, rd1;

   always #5 clk = ~clk;

   spi_reg_slave u_dut0 (
      .clk(clk), .rstb(rstb), .sclk(sclk), .csb(csb0), .sdi(sdi),
      .ascend(ascend), .sdo(sdo0), .sdo_oe(oe0), .reg_addr(addr0),
      .wr_data(wd0), .wr_stb(ws0), .rd_stb(rs0), .rd_data(rd0),
      .busy(busy0)
   );

   spi_reg_slave #(.DATA_W(16), .LSB_FIRST(1)) u_dut1 (
      .clk(clk), .rstb(rstb), .sclk(sclk), .csb(csb1), .sdi(sdi),
      .ascend(ascend), .sdo(sdo1), .sdo_oe(oe1), .reg_addr(addr1),
      .wr_data(wd1), .wr_stb(ws1), .rd_stb(rs1), .rd_data(rd1),
      .busy(busy1)
   );

   int total = 0;
   int bad = 0;
   int nrd = 0;
   int oe_cnt = 0;
   bit sel = 0;
   logic [7:0]  key0 = 8'h00;
   logic [28:0] wq [$];
   logic [15:0] mem1 [0:8191];
   logic [15:0] shadow1 [0:8191];
   logic [15:0] dv [8];

   // Register-file models: dut0 returns addr^key, dut1 is a real memory.
   always @(posedge clk) begin
      if (rs0) begin
         rd0 <= addr0[7:0] ^ key0;
         nrd++;
      end
      if (rs1) begin
         rd1 <= mem1[addr1];
         nrd++;
      end
      if (ws0) wq.push_back({addr0, 8'h00, wd0});
      if (ws1) begin
         wq.push_back({addr1, wd1});
         mem1[addr1] <= wd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bit_x(input logic b, output logic r);
      sdi = b;
      #40;
      r = sel ? sdo1 : sdo0;
      if (sel ? oe1 : oe0) oe_cnt++;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
   endtask

   task automatic word_x(input logic [31:0] v, input int n, input bit lsb,
                         output logic [31:0] got);
      logic r;
      int pos;
      got = '0;
      for (int k = 0; k < n; k++) begin
         pos = lsb ? k : n - 1 - k;
         bit_x(v[pos], r);
         got[pos] = r;
      end
   endtask

   task automatic begin_x(input bit s);
      sel = s;
      sclk = 1'b0;
      oe_cnt = 0;
      @(posedge clk);
      #2;
      if (s) csb1 = 1'b0;
      else   csb0 = 1'b0;
      #40;
   endtask

   task automatic end_x();
      #40;
      csb0 = 1'b1;
      csb1 = 1'b1;
      #200;
   endtask

   task automatic instr(input logic rw, input logic [1:0] w,
                        input logic [12:0] a, input bit lsb);
      logic r;
      logic [31:0] g;
      bit_x(rw, r);
      bit_x(w[1], r);
      bit_x(w[0], r);
      word_x({19'd0, a}, 13, lsb, g);
   endtask

   task automatic rand_fill(input int dw);
      for (int i = 0; i < 8; i++)
         dv[i] = (dw == 16) ? 16'($urandom) : {8'h00, 8'($urandom)};
   endtask

   task automatic run_write(input bit s, input logic [1:0] w, input int nw,
                            input logic [12:0] a, input bit asc,
                            input int dw, input string tag);
      logic [12:0] ea;
      logic [31:0] g;
      logic [28:0] e;
      wq.delete();
      ascend = asc;
      begin_x(s);
      instr(1'b0, w, a, s);
      for (int i = 0; i < nw; i++) word_x({16'd0, dv[i]}, dw, s, g);
      end_x();
      chk({tag, "_nwr"}, wq.size(), nw);
      ea = a;
      for (int i = 0; i < nw; i++) begin
         e = (i < wq.size()) ? wq[i] : 29'h0;
         chk($sformatf("%s_addr%0d", tag, i), e[28:16], ea);
         chk($sformatf("%s_data%0d", tag, i), e[15:0], dv[i]);
         if (s) shadow1[ea] = dv[i];
         ea = asc ? ea + 13'd1 : ea - 13'd1;
      end
   endtask

   task automatic run_read(input bit s, input logic [1:0] w, input int nw,
                           input logic [12:0] a, input bit asc,
                           input int dw, input string tag);
      logic [12:0] ea;
      logic [31:0] g, exp;
      int n0;
      ascend = asc;
      n0 = nrd;
      begin_x(s);
      instr(1'b1, w, a, s);
      ea = a;
      for (int i = 0; i < nw; i++) begin
         word_x(32'd0, dw, s, g);
         exp = s ? {16'd0, shadow1[ea]} : {24'd0, ea[7:0] ^ key0};
         chk($sformatf("%s_rd%0d", tag, i), g, exp);
         ea = asc ? ea + 13'd1 : ea - 13'd1;
      end
      end_x();
      chk({tag, "_nrd"}, nrd - n0, nw);
      chk({tag, "_oecnt"}, oe_cnt, nw * dw);
      chk({tag, "_oe_off"}, s ? oe1 : oe0, 1'b0);
   endtask

   initial begin
      logic r;
      logic [1:0] w;
      logic [12:0] a;
      bit asc;
      rstb = 1'b0;
      sclk = 1'b0;
      sdi = 1'b0;
      ascend = 1'b1;
      csb0 = 1'b1;
      csb1 = 1'b1;
      #25;
      chk("rst_busy", {busy0, busy1}, 2'b00);
      chk("rst_oe", {oe0, oe1}, 2'b00);
      chk("rst_sdo", {sdo0, sdo1}, 2'b00);
      chk("rst_strb", {ws0, rs0, ws1, rs1}, 4'h0);
      chk("rst_addr", addr0, 13'h0);
      chk("rst_wdata", wd0, 8'h00);
      rstb = 1'b1;
      #50;

      rand_fill(8);
      dv[0] = 16'h00A5;
      run_write(0, 2'b00, 1, 13'h0014, 1, 8, "t1");

      key0 = 8'h00;
      run_read(0, 2'b01, 2, 13'h0020, 1, 8, "t2");

      rand_fill(8);
      run_write(0, 2'b11, 3, 13'h1FFF, 1, 8, "t3up");
      rand_fill(8);
      run_write(0, 2'b11, 3, 13'h0000, 0, 8, "t3dn");

      // Abort a write after 5 data bits.
      wq.delete();
      ascend = 1'b1;
      begin_x(0);
      instr(1'b0, 2'b00, 13'h0055, 0);
      for (int i = 0; i < 5; i++) bit_x(1'b1, r);
      csb0 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("t4_busy", busy0, 1'b0);
      #200;
      chk("t4_nowr", wq.size(), 0);
      rand_fill(8);
      run_write(0, 2'b00, 1, 13'($urandom), 1, 8, "t4next");

      // Reset in the middle of a read word.
      key0 = 8'($urandom);
      begin_x(0);
      instr(1'b1, 2'b00, 13'h0abc, 0);
      for (int i = 0; i < 3; i++) bit_x(1'b0, r);
      chk("t5_oe_on", oe0, 1'b1);
      rstb = 1'b0;
      #1;
      chk("t5_oe", oe0, 1'b0);
      chk("t5_sdo", sdo0, 1'b0);
      chk("t5_busy", busy0, 1'b0);
      chk("t5_strb", {ws0, rs0}, 2'b00);
      chk("t5_addr", addr0, 13'h0);
      chk("t5_wdata", wd0, 8'h00);
      csb0 = 1'b1;
      #30;
      rstb = 1'b1;
      #50;
      run_read(0, 2'b01, 2, 13'($urandom), 1, 8, "t5rec");

      // 16-bit LSB-first instance.
      dv[0] = 16'h1234;
      run_write(1, 2'b00, 1, 13'h0003, 1, 16, "t6w");
      run_read(1, 2'b00, 1, 13'h0003, 1, 16, "t6r");
      rand_fill(16);
      a = 13'($urandom);
      run_write(1, 2'b11, 3, a, 0, 16, "t6sw");
      run_read(1, 2'b10, 3, a, 0, 16, "t6sr");

      // Randomized word counts, addresses and direction.
      for (int it = 0; it < 4; it++) begin
         w = 2'($urandom_range(0, 2));
         a = 13'($urandom);
         asc = 1'($urandom);
         key0 = 8'($urandom);
         rand_fill(8);
         run_write(0, w, int'(w) + 1, a, asc, 8, $sformatf("rw%0d", it));
         run_read(0, w, int'(w) + 1, a, asc, 8, $sformatf("rr%0d", it));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
